nubus_memarb: RTL and testbench
===============================

Name: nubus_memarb

Overview:
- Arbitrates card-local memory between two requesters: the NuBus slave path (byte strobes, word address and write data from the slave decoder) and the on-card CPU port.
- Sequences each access: grant, one-cycle memory strobe, read-latency wait, single-cycle acknowledge.
- NuBus has priority, with a bounded-starvation guarantee for the CPU.
- Sits between the NuBus slave/strobe logic and the local memory macro.

Parameters:
- RD_LAT, 1, cycles from the mem_en cycle to mem_rdata_i valid (1..7).
- CPU_STARVE_MAX, 4, consecutive NuBus grants allowed while cpu_req is pending before the CPU is forced a grant (1..15).

Ports:
- nub_clkn  in  1  clock; all logic on rising edge
- nub_reset  in  1  synchronous reset, active-high
- nub_req  in  1  NuBus-side access request, held until nub_ack
- nub_write  in  4  NuBus byte write strobes; 4'b0000 = read
- nub_addr  in  32  NuBus byte address
- nub_wdata  in  32  NuBus write data, true polarity
- nub_ack  out  1  one-cycle completion pulse to NuBus side
- nub_rdata  out  32  NuBus read data, valid while nub_ack=1
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_write  in  4  CPU byte write strobes; 0 = read
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  32  CPU read data, valid while cpu_ack=1
- mem_en  out  1  memory access strobe, one cycle per access
- mem_write_o  out  4  memory byte write enables, zero unless mem_en
- mem_addr_o  out  32  word address {addr[31:2],2'b00}
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data

Behaviour:
- Reset (synchronous, nub_reset=1):
  - State IDLE, starvation count 0, grant owner NuBus.
  - mem_en=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0.
  - nub_ack=0, cpu_ack=0, nub_rdata=0, cpu_rdata=0.
  - Reset mid-access aborts it: no ack is issued, read data is discarded, and the requester must re-issue.
- FSM states: IDLE, ACCESS, RDWAIT, ACK.
- IDLE:
  - Samples nub_req and cpu_req and picks a winner.
  - Registers the winner's write/addr/wdata and the owner, then goes to ACCESS.
  - Stays in IDLE if neither request is high.
- Pick rule:
  - Only one request high: that requester wins.
  - Both high: NuBus wins unless count==CPU_STARVE_MAX, in which case the CPU wins.
- Starvation count:
  - Increments on a NuBus grant made while cpu_req=1, saturating at CPU_STARVE_MAX.
  - Clears on any CPU grant, and on a NuBus grant made while cpu_req=0.
- ACCESS (exactly one cycle):
  - mem_en=1; mem_write_o, mem_addr_o, mem_wdata_o driven from the registered request.
  - Write (strobes nonzero): next state ACK.
  - Read: next state RDWAIT with the latency counter loaded to RD_LAT.
- RDWAIT:
  - Counter decrements each cycle.
  - On the cycle it reaches 0, mem_rdata_i is captured into the owner's rdata register and the next state is ACK.
- ACK (one cycle):
  - Owner's ack=1; the other ack=0.
  - Requests are ignored during ACK; next state IDLE.
  - Requester deasserts req or presents a new request in the cycle after ack.
- Latency (request first high in IDLE cycle N):
  - Write: mem_en at N+1, ack at N+2.
  - Read: mem_en at N+1, capture at N+1+RD_LAT, ack at N+2+RD_LAT.
  - Back-to-back write throughput: one per 3 cycles.
- Data and address rules:
  - mem_write_o is the request strobes passed through unmodified; all 16 patterns are allowed.
  - Address bits [1:0] are dropped.
  - rdata registers hold their value until the next capture for the same owner.
- Request changes: changes to a request's fields after its grant (after IDLE) are ignored until the next IDLE.

Decomposition:
- Shared package nubus_pkg:
  - state enum {IDLE, ACCESS, RDWAIT, ACK}
  - owner constants OWN_NUB=0, OWN_CPU=1
  - WORD_MASK = 32'hFFFF_FFFC
- One natural sub-module, nubus_memarb_pick:
  - Holds the starvation counter and the winner-select logic.
  - Inputs: nub_req, cpu_req, grant strobe, reset.
  - Output: owner.

Test Plan:
- Single NuBus write: nub_req=1, nub_write=4'b1100, nub_addr=32'h0000_1006, nub_wdata=32'hDEAD_BEEF.
  -> mem_en 1 cycle with mem_addr_o=32'h0000_1004, mem_write_o=4'b1100, mem_wdata_o=32'hDEAD_BEEF; nub_ack 1 cycle later; cpu_ack stays 0.
- CPU read, RD_LAT=2: cpu_addr=32'h40, memory returns 32'h1234_5678 two cycles after mem_en.
  -> cpu_ack 4 cycles after request; cpu_rdata=32'h1234_5678 during cpu_ack.
- Starvation, CPU_STARVE_MAX=4: nub_req and cpu_req both held high, each re-requesting after ack.
  -> grant order NUB, NUB, NUB, NUB, CPU, NUB...
- Simultaneous requests, count=0: both requests asserted in the same IDLE cycle.
  -> NuBus granted first; CPU served next; count reads 0 after the CPU grant.
- Reset during RDWAIT: nub_reset=1 while a read is in RDWAIT.
  -> next cycle all outputs are 0 and state is IDLE; no ack pulse ever appears for that read.
- Zero-strobe vs full-word: nub_write=4'b0000 is treated as a read; nub_write=4'b1111 writes all four bytes with no RDWAIT.

Source files
------------

// File: rtl/nubus_pkg.sv
// Shared definitions for the NuBus card-local memory arbiter.
//   state_t   : access sequencer states
//   OWN_*     : grant owner encoding
//   WORD_MASK : clears the byte-offset bits of a byte address
package nubus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic OWN_NUB = 1'b0;
  localparam logic OWN_CPU = 1'b1;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/nubus_memarb_pick.sv
// Winner selection and CPU starvation counter.
//   i_clk     : clock, rising edge
//   i_rst     : synchronous active-high reset, clears the starvation count
//   i_nub_req : NuBus request
//   i_cpu_req : CPU request
//   i_grant   : a grant is being made this cycle to o_owner
//   o_owner   : winner if a grant were made now (OWN_NUB / OWN_CPU)
module nubus_memarb_pick
  import nubus_pkg::*;
#(
  parameter int CPU_STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_nub_req,
  input  logic i_cpu_req,
  input  logic i_grant,
  output logic o_owner
);

  logic [3:0] r_cnt;
  logic       w_cnt_full;
  logic       w_cpu_wins;

  assign w_cnt_full = (r_cnt == 4'(CPU_STARVE_MAX));
  // NuBus normally wins a tie; the CPU takes the tie once it has been
  // passed over CPU_STARVE_MAX times in a row.
  assign w_cpu_wins = i_cpu_req && (!i_nub_req || w_cnt_full);
  assign o_owner    = w_cpu_wins ? OWN_CPU : OWN_NUB;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_grant) begin
      if (w_cpu_wins || !i_cpu_req) begin
        r_cnt <= '0;
      end else if (!w_cnt_full) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/nubus_memarb.sv
// Card-local memory arbiter between the NuBus slave path and the CPU port.
// Each access runs grant -> one-cycle mem_en -> read-latency wait -> ack.
//   nub_clkn, nub_reset          : clock and synchronous active-high reset
//   nub_req/write/addr/wdata     : NuBus-side request, held until nub_ack
//   nub_ack, nub_rdata           : NuBus completion pulse and read data
//   cpu_req/write/addr/wdata     : CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata           : CPU completion pulse and read data
//   mem_en, mem_write_o, mem_addr_o, mem_wdata_o, mem_rdata_i : memory macro
module nubus_memarb
  import nubus_pkg::*;
#(
  parameter int RD_LAT         = 1,
  parameter int CPU_STARVE_MAX = 4
) (
  input  logic        nub_clkn,
  input  logic        nub_reset,
  input  logic        nub_req,
  input  logic [3:0]  nub_write,
  input  logic [31:0] nub_addr,
  input  logic [31:0] nub_wdata,
  output logic        nub_ack,
  output logic [31:0] nub_rdata,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  state_t      r_state;
  logic        r_owner;
  logic [3:0]  r_write;
  logic [2:0]  r_lat;

  logic        w_grant;
  logic        w_owner;
  logic [3:0]  w_write;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  assign w_grant = (r_state == IDLE) && (nub_req || cpu_req);
  assign w_write = (w_owner == OWN_CPU) ? cpu_write : nub_write;
  assign w_addr  = (w_owner == OWN_CPU) ? cpu_addr  : nub_addr;
  assign w_wdata = (w_owner == OWN_CPU) ? cpu_wdata : nub_wdata;

  nubus_memarb_pick #(
    .CPU_STARVE_MAX (CPU_STARVE_MAX)
  ) u_pick (
    .i_clk     (nub_clkn),
    .i_rst     (nub_reset),
    .i_nub_req (nub_req),
    .i_cpu_req (cpu_req),
    .i_grant   (w_grant),
    .o_owner   (w_owner)
  );

  always_ff @(posedge nub_clkn) begin
    if (nub_reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_NUB;
      r_write     <= '0;
      r_lat       <= '0;
      mem_en      <= 1'b0;
      mem_write_o <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      nub_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      nub_rdata   <= '0;
      cpu_rdata   <= '0;
    end else begin
      // Strobes and acks are single-cycle pulses; only the state that
      // raises them re-asserts them.
      mem_en      <= 1'b0;
      mem_write_o <= '0;
      nub_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            // mem_addr_o/mem_wdata_o double as the registered request and
            // stay put until the next grant, so later request changes are
            // ignored.
            r_owner     <= w_owner;
            r_write     <= w_write;
            mem_en      <= 1'b1;
            mem_write_o <= w_write;
            mem_addr_o  <= w_addr & WORD_MASK;
            mem_wdata_o <= w_wdata;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_write != 4'b0000) begin
            nub_ack <= (r_owner == OWN_NUB);
            cpu_ack <= (r_owner == OWN_CPU);
            r_state <= ACK;
          end else begin
            r_lat   <= 3'(RD_LAT);
            r_state <= RDWAIT;
          end
        end
        RDWAIT: begin
          r_lat <= r_lat - 3'd1;
          // r_lat==1 is the cycle the counter reaches zero: read data is
          // valid RD_LAT cycles after mem_en.
          if (r_lat == 3'd1) begin
            if (r_owner == OWN_CPU) cpu_rdata <= mem_rdata_i;
            else                    nub_rdata <= mem_rdata_i;
            nub_ack <= (r_owner == OWN_NUB);
            cpu_ack <= (r_owner == OWN_CPU);
            r_state <= ACK;
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nubus_memarb.sv
// Self-checking bench for nubus_memarb: randomized requesters on both ports,
// a behavioural memory macro, and a transaction-level reference model whose
// expectations are queued and checked by a monitor on the falling edge.
module tb_nubus_memarb;

  localparam int RD_LAT = 2;
  localparam int SMAX   = 4;

  logic        clk = 1'b0;
  logic        nub_reset;
  logic        nub_req;
  logic [3:0]  nub_write;
  logic [31:0] nub_addr;
  logic [31:0] nub_wdata;
  logic        nub_ack;
  logic [31:0] nub_rdata;
  logic        cpu_req;
  logic [3:0]  cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        mem_en;
  logic [3:0]  mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  nubus_memarb #(
    .RD_LAT         (RD_LAT),
    .CPU_STARVE_MAX (SMAX)
  ) dut (
    .nub_clkn    (clk),
    .nub_reset   (nub_reset),
    .nub_req     (nub_req),
    .nub_write   (nub_write),
    .nub_addr    (nub_addr),
    .nub_wdata   (nub_wdata),
    .nub_ack     (nub_ack),
    .nub_rdata   (nub_rdata),
    .cpu_req     (cpu_req),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .mem_en      (mem_en),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
  } mexp_t;

  typedef struct {
    int          cyc;
    logic        own;
    logic [31:0] rd;
  } aexp_t;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  mexp_t       mq[$];
  aexp_t       aq[$];
  logic [31:0] macro_mem[16];
  logic [31:0] shadow[16];
  logic [31:0] last_rd[2];
  int          free_at = 0;
  int          scnt = 0;
  int          rd_due = -1;
  logic [31:0] rd_val;
  logic        glog[$];
  bit          log_en = 1'b0;
  logic [31:0] last_cpu_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [3:0] rstrb();
    logic [3:0] s;
    s = 4'($urandom());
    if ($urandom_range(0, 2) == 0) s = 4'b0000;
    return s;
  endfunction

  // Memory macro, monitor and reference model share one falling-edge block
  // so their order within a cycle is fixed.
  always @(negedge clk) begin
    mexp_t       me;
    aexp_t       ae;
    logic        cw;
    logic        own;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    int          idx;

    // memory macro: read data valid only RD_LAT cycles after mem_en
    if (cyc == rd_due) mem_rdata_i = rd_val;
    else               mem_rdata_i = $urandom();
    if (mem_en === 1'b1) begin
      idx = int'(mem_addr_o[5:2]);
      if (mem_write_o != 4'b0000) macro_mem[idx] = merge(macro_mem[idx], mem_wdata_o, mem_write_o);
      else begin
        rd_due = cyc + RD_LAT;
        rd_val = macro_mem[idx];
      end
    end

    // monitor
    if (mem_en === 1'b1) begin
      if (mq.size() == 0) chk("unexpected_mem_en", 32'd1, 32'd0);
      else begin
        me = mq.pop_front();
        chk("mem_en_cycle", cyc, me.cyc);
        chk("mem_write_o", {28'd0, mem_write_o}, {28'd0, me.w});
        chk("mem_addr_o", mem_addr_o, me.a);
        chk("mem_wdata_o", mem_wdata_o, me.d);
      end
    end else begin
      chk("mem_write_idle", {28'd0, mem_write_o}, 32'd0);
    end
    if (nub_ack === 1'b1 || cpu_ack === 1'b1) begin
      chk("dual_ack", {31'd0, nub_ack & cpu_ack}, 32'd0);
      own = cpu_ack;
      if (log_en) glog.push_back(own);
      if (own) last_cpu_rd = cpu_rdata;
      if (aq.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else begin
        ae = aq.pop_front();
        chk("ack_cycle", cyc, ae.cyc);
        chk("ack_owner", {31'd0, own}, {31'd0, ae.own});
        chk("ack_rdata", own ? cpu_rdata : nub_rdata, ae.rd);
      end
    end

    // reference model: one access at a time, busy 3 cycles for a write
    // and 3+RD_LAT for a read, from the cycle the grant is decided
    if (nub_reset === 1'b1) begin
      aq.delete();
      mq.delete();
      scnt       = 0;
      free_at    = cyc + 1;
      last_rd[0] = '0;
      last_rd[1] = '0;
    end else if (cyc >= free_at && (nub_req === 1'b1 || cpu_req === 1'b1)) begin
      cw = (cpu_req === 1'b1) && (nub_req !== 1'b1 || scnt == SMAX);
      if (cw || cpu_req !== 1'b1) scnt = 0;
      else if (scnt < SMAX) scnt = scnt + 1;
      w = cw ? cpu_write : nub_write;
      a = cw ? cpu_addr  : nub_addr;
      d = cw ? cpu_wdata : nub_wdata;
      mq.push_back('{cyc + 1, w, a & ~32'h3, d});
      idx = int'(a[5:2]);
      if (w != 4'b0000) begin
        shadow[idx] = merge(shadow[idx], d, w);
        aq.push_back('{cyc + 2, cw, last_rd[int'(cw)]});
        free_at = cyc + 3;
      end else begin
        last_rd[int'(cw)] = shadow[idx];
        aq.push_back('{cyc + 2 + RD_LAT, cw, shadow[idx]});
        free_at = cyc + 3 + RD_LAT;
      end
    end
  end

  task automatic nub_go(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        input int gap);
    int n;
    @(posedge clk); #1;
    if (gap > 0) begin
      nub_req = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    nub_req = 1'b1; nub_write = w; nub_addr = a; nub_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (nub_ack !== 1'b1 && n < 400);
    chk("nub_ack_timeout", {31'd0, nub_ack}, 32'd1);
  endtask

  task automatic cpu_go(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        input int gap);
    int n;
    @(posedge clk); #1;
    if (gap > 0) begin
      cpu_req = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    cpu_req = 1'b1; cpu_write = w; cpu_addr = a; cpu_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (cpu_ack !== 1'b1 && n < 400);
    chk("cpu_ack_timeout", {31'd0, cpu_ack}, 32'd1);
  endtask

  task automatic nub_idle();
    @(posedge clk); #1;
    nub_req = 1'b0;
  endtask

  task automatic cpu_idle();
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_en"},  {31'd0, mem_en}, 32'd0);
    chk({tag, "_mem_wr"},  {28'd0, mem_write_o}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_nub_ack"}, {31'd0, nub_ack}, 32'd0);
    chk({tag, "_cpu_ack"}, {31'd0, cpu_ack}, 32'd0);
    chk({tag, "_nub_rdata"}, nub_rdata, 32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      macro_mem[i] = '0;
      shadow[i]    = '0;
    end
    last_rd[0] = '0;
    last_rd[1] = '0;
    nub_reset = 1'b1;
    nub_req = 1'b0; nub_write = '0; nub_addr = '0; nub_wdata = '0;
    cpu_req = 1'b0; cpu_write = '0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    nub_reset = 1'b0;

    // directed transactions from the test plan
    nub_go(4'b1100, 32'h0000_1006, 32'hDEAD_BEEF, 0);
    nub_idle();
    cpu_go(4'b1111, 32'h0000_0040, 32'h1234_5678, 1);
    cpu_go(4'b0000, 32'h0000_0040, 32'h0, 1);
    cpu_idle();
    chk("cpu_read_0x40", last_cpu_rd, 32'h1234_5678);
    nub_go(4'b0000, 32'h0000_1004, 32'h0, 1);
    nub_go(4'b1111, 32'h0000_1008, 32'hCAFE_F00D, 1);
    nub_idle();

    // simultaneous requests with count 0: NuBus first, then CPU
    glog.delete();
    log_en = 1'b1;
    fork
      begin nub_go(4'b0001, 32'h0000_0010, 32'h0000_00AA, 0); nub_idle(); end
      begin cpu_go(4'b0000, 32'h0000_0010, 32'h0, 0); cpu_idle(); end
    join
    chk("simul_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("simul_first_nub", {31'd0, glog[0]}, 32'd0);
      chk("simul_then_cpu", {31'd0, glog[1]}, 32'd1);
    end

    // starvation: both held, re-requesting right after each ack
    glog.delete();
    fork
      begin
        repeat (8) nub_go(4'b1111, $urandom(), $urandom(), 0);
        nub_idle();
      end
      begin
        repeat (2) cpu_go(4'b1111, $urandom(), $urandom(), 0);
        cpu_idle();
      end
    join
    log_en = 1'b0;
    chk("starve_count", glog.size(), 10);
    for (int i = 0; i < 10 && i < glog.size(); i++)
      chk($sformatf("starve_grant%0d", i), {31'd0, glog[i]},
          (i % (SMAX + 1) == SMAX) ? 32'd1 : 32'd0);

    // randomized traffic on both ports
    fork
      begin
        for (int i = 0; i < 40; i++)
          nub_go(rstrb(), $urandom(), $urandom(), $urandom_range(0, 3));
        nub_idle();
      end
      begin
        for (int j = 0; j < 40; j++)
          cpu_go(rstrb(), $urandom(), $urandom(), $urandom_range(0, 3));
        cpu_idle();
      end
    join

    // reset while a NuBus read sits in RDWAIT
    @(posedge clk); #1;
    nub_req = 1'b1; nub_write = 4'b0000; nub_addr = 32'h0000_2024; nub_wdata = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (mem_en !== 1'b1 && n < 50);
    chk("rdwait_mem_en_seen", {31'd0, mem_en}, 32'd1);
    @(posedge clk); #1;
    nub_reset = 1'b1;
    @(posedge clk); #1;
    nub_reset = 1'b0;
    nub_req   = 1'b0;
    @(negedge clk);
    chk_all_zero("rdwait_reset");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("no_ack_after_reset", {31'd0, nub_ack | cpu_ack}, 32'd0);
    end

    chk("mem_queue_drained", mq.size(), 0);
    chk("ack_queue_drained", aq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
